// File: rtl/div_share_arb.sv
// Round-robin front end sharing one fixed-latency pipelined divider among NUM_REQ requesters.
// Optional macro DIV_ZERO_BYPASS_EN: answer divide-by-zero locally instead of sending it to the core.
module div_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int DIV_LAT = 20
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*25-1:0]         req_dividend,
    input  logic [NUM_REQ*16-1:0]         req_divisor,
    output logic                          rsp_valid,
    output logic [IDW-1:0]                rsp_id,
    output logic [24:0]                   rsp_quotient,
    output logic [15:0]                   rsp_fractional,
    output logic                          rsp_dz,
    output logic [$clog2(DIV_LAT+2):0]    inflight,
    output logic [24:0]                   div_dividend,
    output logic [15:0]                   div_divisor,
    output logic                          div_ce,
    input  logic                          div_rfd,
    input  logic [24:0]                   div_quotient,
    input  logic [15:0]                   div_fractional
);

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           dz;
    } tag_t;

    logic [IDW-1:0] rr;
    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [24:0]    win_dividend;
    logic [15:0]    win_divisor;
    logic           grant_dz;
    tag_t           tag_pipe [DIV_LAT+1];
    tag_t           tag_out;

    // Search from the rr pointer upward with wrap; first valid requester wins.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        idx          = 0;
        req_ready    = '0;
        grant_any    = 1'b0;
        grant_id     = '0;
        win_dividend = '0;
        win_divisor  = '0;
        if (div_ce && div_rfd) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!grant_any && req_valid[idx]) begin
                    grant_any      = 1'b1;
                    grant_id       = IDW'(idx);
                    req_ready[idx] = 1'b1;
                    win_dividend   = req_dividend[idx*25 +: 25];
                    win_divisor    = req_divisor[idx*16 +: 16];
                end
            end
        end
    end

`ifdef DIV_ZERO_BYPASS_EN
    assign grant_dz = (win_divisor == 16'd0);
`else
    assign grant_dz = 1'b0;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_ce       <= 1'b0;
            rr           <= '0;
            div_dividend <= '0;
            div_divisor  <= 16'd1;
        end else begin
            div_ce <= 1'b1;
            if (grant_any) begin
                rr <= (grant_id == IDW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                // A bypassed zero divisor never reaches the core, so its inputs stay nonzero.
                if (!grant_dz) begin
                    div_dividend <= win_dividend;
                    div_divisor  <= win_divisor;
                end
            end
        end
    end

    // NOTE: the tag pipe is a register chain, not a RAM, so every stage is cleared on reset;
    // this is what discards results that were in flight when reset arrived.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i <= DIV_LAT; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: grant_any, id: grant_id, dz: grant_dz};
            for (int i = 1; i <= DIV_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign tag_out = tag_pipe[DIV_LAT];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_quotient   <= '0;
            rsp_fractional <= '0;
            rsp_dz         <= 1'b0;
        end else begin
            rsp_valid <= tag_out.valid;
            if (tag_out.valid) begin
                rsp_id         <= tag_out.id;
                rsp_quotient   <= tag_out.dz ? '1 : div_quotient;
                rsp_fractional <= tag_out.dz ? '0 : div_fractional;
                rsp_dz         <= tag_out.dz;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            inflight <= '0;
        end else begin
            unique case ({grant_any, rsp_valid})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

endmodule
